// File: rtl/mem_burst_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_fsm
// Description : Burst read/write sequencer with per-beat ready handshake,
//               stall timeout and abort. Sits between a command front-end
//               and a single-port memory interface.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_fsm #(
   parameter int ADDR_W  = 16,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 15,
   parameter bit REG_OUT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr_mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              abort,
   input  logic              mem_ready,
   output logic              rd,
   output logic              wr,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int OUT_W  = ADDR_W + 5;

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_read  = 3'd1;
   localparam logic [2:0] c_write = 3'd2;
   localparam logic [2:0] c_done  = 3'd3;
   localparam logic [2:0] c_err   = 3'd4;

   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WAIT_W-1:0] c_wait_max  = '1;

   logic [2:0]        r_state, w_next_state;
   logic [LEN_W-1:0]  r_beat,  w_next_beat;
   logic [LEN_W-1:0]  r_len,   w_next_len;
   logic [WAIT_W-1:0] r_wait,  w_next_wait;
   logic [ADDR_W-1:0] r_base,  w_next_base;
   logic [LEN_W-1:0]  w_beat_inc;
   logic [OUT_W-1:0]  w_out;

   assign w_beat_inc = r_beat + LEN_W'(1);

   always_comb begin
      w_next_state = r_state;
      w_next_beat  = r_beat;
      w_next_len   = r_len;
      w_next_wait  = r_wait;
      w_next_base  = r_base;
      case (r_state)
         c_idle: begin
            if (start) begin
               w_next_base = base_addr;
               w_next_len  = burst_len;
               w_next_beat = '0;
               w_next_wait = '0;
               if (burst_len == '0)
                  w_next_state = c_done;
               else if (wr_mode)
                  w_next_state = c_write;
               else
                  w_next_state = c_read;
            end
         end
         c_read, c_write: begin
            // Abort wins over both a transfer and a timeout in the same cycle
            if (abort) begin
               w_next_state = c_idle;
            end else if (mem_ready) begin
               w_next_beat = w_beat_inc;
               w_next_wait = '0;
               if (w_beat_inc == r_len)
                  w_next_state = c_done;
            end else begin
               if (r_wait != c_wait_max)
                  w_next_wait = r_wait + WAIT_W'(1);
               if ((TIMEOUT != 0) && (r_wait == c_wait_last))
                  w_next_state = c_err;
            end
         end
         default: w_next_state = c_idle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_beat  <= '0;
         r_len   <= '0;
         r_wait  <= '0;
         r_base  <= '0;
      end else begin
         r_state <= w_next_state;
         r_beat  <= w_next_beat;
         r_len   <= w_next_len;
         r_wait  <= w_next_wait;
         r_base  <= w_next_base;
      end
   end

   // Packed as {rd, wr, busy, done, err, addr}; shared by both output styles
   function automatic logic [OUT_W-1:0] f_decode(input logic [2:0]        state,
                                                 input logic [LEN_W-1:0]  beat,
                                                 input logic [ADDR_W-1:0] base);
      logic [ADDR_W-1:0] a;
      a = '0;
      if ((state == c_read) || (state == c_write))
         a = base + ADDR_W'(beat);
      return {state == c_read, state == c_write, state != c_idle,
              state == c_done, state == c_err, a};
   endfunction

   generate
      if (REG_OUT) begin : g_reg_out
         logic [OUT_W-1:0] r_out;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_out <= '0;
            else
               r_out <= f_decode(w_next_state, w_next_beat, w_next_base);
         end
         assign w_out = r_out;
      end else begin : g_comb_out
         assign w_out = f_decode(r_state, r_beat, r_base);
      end
   endgenerate

   assign {rd, wr, busy, done, err, addr} = w_out;

endmodule
`default_nettype wire
